// File: rtl/vga_sync_receiver.sv
// rtl/vga_sync_receiver.sv - VGA timing receiver: coordinate recovery, timing measurement and lock
module vga_sync_receiver #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int COLOR_DEPTH = 9,
    parameter int LOCK_FRAMES = 2
) (
    input  logic                   vga_clock,
    input  logic                   resetn,
    input  logic                   hs_n,
    input  logic                   vs_n,
    input  logic                   blank_n,
    input  logic [COLOR_DEPTH-1:0] color_in,
    output logic [9:0]             rx_x,
    output logic [9:0]             rx_y,
    output logic [COLOR_DEPTH-1:0] rx_color,
    output logic                   pixel_valid,
    output logic                   frame_start,
    output logic                   locked,
    output logic                   timing_err,
    output logic [10:0]            h_period,
    output logic [9:0]             v_lines
);

    localparam logic [10:0] H_MAX     = 11'h7FF;
    localparam logic [9:0]  L_MAX     = 10'h3FF;
    localparam logic [10:0] H_TOT_L   = 11'(H_TOTAL);
    localparam logic [9:0]  H_ACT_L   = 10'(H_ACTIVE);
    localparam logic [9:0]  V_TOT_L   = 10'(V_TOTAL);
    localparam logic [9:0]  V_ACT_L   = 10'(V_ACTIVE);
    localparam logic [2:0]  LOCK_L    = 3'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    // stage 1 samples and their previous values
    logic                   hs_q, vs_q, blank_q;
    logic                   hs_qq, vs_qq, blank_qq;
    logic [COLOR_DEPTH-1:0] color_q;

    // timing counters
    logic [10:0] hcnt;
    logic [9:0]  line_cnt;
    logic [9:0]  act_cnt;
    logic [9:0]  pix_cnt;

    // fsm
    state_t      state, state_next;
    logic [2:0]  good_cnt, good_next;
    logic        err_now;
    logic        fs_now;

    // combinational helpers
    logic        hs_fall, vs_fall, blank_rise, blank_fall;
    logic [10:0] h_meas;
    logic [9:0]  lines_seen;
    logic [9:0]  act_seen;
    logic [9:0]  x_now;
    logic [9:0]  x_next;
    logic        line_bad, pix_bad, frame_bad, any_bad;

    // Stage 1: register the raw link; reset values look like idle blanking so no false edge follows reset
    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            blank_q  <= 1'b0;
            hs_qq    <= 1'b1;
            vs_qq    <= 1'b1;
            blank_qq <= 1'b0;
            color_q  <= '0;
        end else begin
            hs_q     <= hs_n;
            vs_q     <= vs_n;
            blank_q  <= blank_n;
            hs_qq    <= hs_q;
            vs_qq    <= vs_q;
            blank_qq <= blank_q;
            color_q  <= color_in;
        end
    end

    assign hs_fall    = hs_qq & ~hs_q;
    assign vs_fall    = vs_qq & ~vs_q;
    assign blank_rise = ~blank_qq & blank_q;
    assign blank_fall = blank_qq & ~blank_q;

    // Measured values include the edge happening this cycle, so a coincident hs/vs fall counts that line
    assign h_meas     = (hcnt == H_MAX) ? H_MAX : hcnt + 11'd1;
    assign lines_seen = (hs_fall && line_cnt != L_MAX) ? line_cnt + 10'd1 : line_cnt;
    assign act_seen   = (blank_fall && act_cnt != L_MAX) ? act_cnt + 10'd1 : act_cnt;
    assign x_now      = blank_rise ? 10'd0 : pix_cnt;
    assign x_next     = (x_now == L_MAX) ? L_MAX : x_now + 10'd1;

    // Timing checks against the nominal mode; all use pre-clear counter values
    assign line_bad  = hs_fall && (h_meas != H_TOT_L);
    assign pix_bad   = blank_fall && (pix_cnt != H_ACT_L);
    assign frame_bad = vs_fall && ((lines_seen != V_TOT_L) || (act_seen != V_ACT_L));
    assign any_bad   = line_bad | pix_bad | frame_bad;

    // Line, frame and active-region counters; all saturate instead of wrapping
    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
            hcnt     <= '0;
            line_cnt <= '0;
            act_cnt  <= '0;
            pix_cnt  <= '0;
        end else begin
            hcnt     <= hs_fall ? 11'd0 : h_meas;
            line_cnt <= vs_fall ? 10'd0 : lines_seen;
            act_cnt  <= vs_fall ? 10'd0 : act_seen;
            if (blank_q) begin
                pix_cnt <= x_next;
            end
        end
    end

    // FSM state register
    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_SEARCH;
            good_cnt <= '0;
        end else begin
            state    <= state_next;
            good_cnt <= good_next;
        end
    end

    // FSM next state: search for a frame boundary, count clean frames, drop out on any error
    always_comb begin
        state_next = state;
        good_next  = good_cnt;
        err_now    = 1'b0;
        fs_now     = 1'b0;
        case (state)
            ST_SEARCH: begin
                if (vs_fall) begin
                    state_next = ST_MEASURE;
                    good_next  = '0;
                end
            end
            ST_MEASURE: begin
                err_now = any_bad;
                if (any_bad) begin
                    state_next = ST_SEARCH;
                    good_next  = '0;
                end else if (vs_fall) begin
                    if (good_cnt + 3'd1 >= LOCK_L) begin
                        state_next = ST_LOCKED;
                        good_next  = '0;
                    end else begin
                        good_next = good_cnt + 3'd1;
                    end
                end
            end
            ST_LOCKED: begin
                err_now = any_bad;
                fs_now  = vs_fall && !any_bad;
                if (any_bad) begin
                    state_next = ST_SEARCH;
                    good_next  = '0;
                end
            end
            default: begin
                state_next = ST_SEARCH;
                good_next  = '0;
            end
        endcase
    end

    // Stage 2: registered outputs, two cycles after the input sample
    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
            rx_x        <= '0;
            rx_y        <= '0;
            rx_color    <= '0;
            pixel_valid <= 1'b0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            timing_err  <= 1'b0;
            h_period    <= '0;
            v_lines     <= '0;
        end else begin
            rx_x        <= x_now;
            rx_y        <= act_cnt;
            rx_color    <= color_q;
            pixel_valid <= (state == ST_LOCKED) && blank_q;
            frame_start <= fs_now;
            locked      <= (state_next == ST_LOCKED);
            timing_err  <= err_now;
            if (hs_fall) begin
                h_period <= h_meas;
            end
            if (vs_fall) begin
                v_lines <= lines_seen;
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb/tb_vga_sync_receiver.sv - randomized self-checking bench for vga_sync_receiver
module tb_vga_sync_receiver;

    localparam int H_TOT    = 40;
    localparam int H_ACT    = 24;
    localparam int V_TOT    = 20;
    localparam int V_ACT    = 12;
    localparam int LOCK_N   = 2;
    localparam int HS_START = H_ACT + 4;
    localparam int HS_W     = 4;
    localparam int VS_LINE  = V_ACT + 2;

    localparam int P_SEARCH  = 0;
    localparam int P_MEASURE = 1;
    localparam int P_LOCKED  = 2;

    logic       vga_clock = 1'b0;
    logic       resetn;
    logic       hs_n, vs_n, blank_n;
    logic [8:0] color_in;
    logic [9:0] rx_x, rx_y;
    logic [8:0] rx_color;
    logic       pixel_valid, frame_start, locked, timing_err;
    logic [10:0] h_period;
    logic [9:0]  v_lines;

    vga_sync_receiver #(
        .H_TOTAL(H_TOT), .V_TOTAL(V_TOT), .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT),
        .COLOR_DEPTH(9), .LOCK_FRAMES(LOCK_N)
    ) dut (
        .vga_clock(vga_clock), .resetn(resetn), .hs_n(hs_n), .vs_n(vs_n),
        .blank_n(blank_n), .color_in(color_in), .rx_x(rx_x), .rx_y(rx_y),
        .rx_color(rx_color), .pixel_valid(pixel_valid), .frame_start(frame_start),
        .locked(locked), .timing_err(timing_err), .h_period(h_period), .v_lines(v_lines)
    );

    always #5 vga_clock = ~vga_clock;

    typedef struct {
        int pv, fs, err, lk, x, y, c, hp, hpk, vl;
    } exp_t;

    exp_t q[$];

    int total = 0;
    int bad   = 0;

    // reference model state, event based on the driven samples
    int t, last_hs_t, rise_t, lines, act_lines, phase, good, m_hp, m_vl;
    bit p_hs, p_vs, p_bl, hs_known, hp_known;

    // monitor
    int pv_cnt, fs_cnt, err_cnt, first_x, first_y, last_x, last_y, last_err_hp, last_err_lk;
    bit seen_pv;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        t = 0; last_hs_t = 0; rise_t = 0; lines = 0; act_lines = 0;
        phase = P_SEARCH; good = 0; m_hp = 0; m_vl = 0;
        p_hs = 1; p_vs = 1; p_bl = 0; hs_known = 0; hp_known = 1;
    endtask

    task automatic model_step(input bit hs, input bit vs, input bit bl, input int col,
                              input int x, input int y, output exp_t r);
        bit hf, vf, bf, br, b;
        int per, run;
        hf = p_hs && !hs;
        vf = p_vs && !vs;
        bf = p_bl && !bl;
        br = !p_bl && bl;
        b = 0;
        per = 0;
        if (hf) begin
            if (hs_known) begin
                per = t - last_hs_t;
                if (per > 2047) per = 2047;
                if (per != H_TOT) b = 1;
            end
            if (lines < 1023) lines++;
        end
        if (bf) begin
            run = t - rise_t;
            if (run > 1023) run = 1023;
            if (run != H_ACT) b = 1;
            if (act_lines < 1023) act_lines++;
        end
        if (br) rise_t = t;
        if (vf && (lines != V_TOT || act_lines != V_ACT)) b = 1;
        r.pv  = (phase == P_LOCKED && bl) ? 1 : 0;
        r.x   = x;
        r.y   = y;
        r.c   = col;
        r.err = (phase != P_SEARCH && b) ? 1 : 0;
        r.fs  = (phase == P_LOCKED && vf && !b) ? 1 : 0;
        if (phase == P_SEARCH) begin
            if (vf) begin phase = P_MEASURE; good = 0; end
        end else if (b) begin
            phase = P_SEARCH;
        end else if (phase == P_MEASURE && vf) begin
            good++;
            if (good >= LOCK_N) phase = P_LOCKED;
        end
        r.lk = (phase == P_LOCKED) ? 1 : 0;
        if (hf) begin
            hp_known = hs_known;
            if (hs_known) m_hp = per;
            last_hs_t = t;
            hs_known = 1;
        end
        if (vf) begin
            m_vl = lines;
            lines = 0;
            act_lines = 0;
        end
        r.hp  = m_hp;
        r.hpk = hp_known ? 1 : 0;
        r.vl  = m_vl;
        p_hs = hs; p_vs = vs; p_bl = bl;
        t++;
    endtask

    task automatic clr_mon();
        pv_cnt = 0; fs_cnt = 0; err_cnt = 0; seen_pv = 0;
        first_x = -1; first_y = -1; last_x = -1; last_y = -1;
        last_err_hp = -1; last_err_lk = -1;
    endtask

    task automatic tick(input bit hs, input bit vs, input bit bl, input logic [8:0] col,
                        input int x, input int y);
        exp_t e, r;
        @(negedge vga_clock);
        if (q.size() == 2) begin
            e = q.pop_front();
            check_eq("pixel_valid", 32'(pixel_valid), e.pv);
            check_eq("frame_start", 32'(frame_start), e.fs);
            check_eq("timing_err", 32'(timing_err), e.err);
            check_eq("locked", 32'(locked), e.lk);
            check_eq("rx_color", 32'(rx_color), e.c);
            check_eq("v_lines", 32'(v_lines), e.vl);
            if (e.hpk != 0) check_eq("h_period", 32'(h_period), e.hp);
            if (e.pv != 0) begin
                check_eq("rx_x", 32'(rx_x), e.x);
                check_eq("rx_y", 32'(rx_y), e.y);
            end
        end
        if (pixel_valid) begin
            pv_cnt++;
            if (!seen_pv) begin first_x = int'(rx_x); first_y = int'(rx_y); seen_pv = 1; end
            last_x = int'(rx_x);
            last_y = int'(rx_y);
        end
        if (frame_start) fs_cnt++;
        if (timing_err) begin
            err_cnt++;
            last_err_hp = int'(h_period);
            last_err_lk = int'(locked);
        end
        hs_n = hs; vs_n = vs; blank_n = bl; color_in = col;
        model_step(hs, vs, bl, int'(col), x, y, r);
        q.push_back(r);
    endtask

    task automatic do_reset(input int hold);
        exp_t z, r;
        @(negedge vga_clock);
        resetn = 1'b0;
        hs_n = 1'b1; vs_n = 1'b1; blank_n = 1'b0; color_in = '0;
        #1;
        check_eq("rst_pixel_valid", 32'(pixel_valid), 0);
        check_eq("rst_frame_start", 32'(frame_start), 0);
        check_eq("rst_locked", 32'(locked), 0);
        check_eq("rst_timing_err", 32'(timing_err), 0);
        check_eq("rst_rx_x", 32'(rx_x), 0);
        check_eq("rst_rx_y", 32'(rx_y), 0);
        check_eq("rst_rx_color", 32'(rx_color), 0);
        check_eq("rst_h_period", 32'(h_period), 0);
        check_eq("rst_v_lines", 32'(v_lines), 0);
        repeat (hold) @(negedge vga_clock);
        resetn = 1'b1;
        model_reset();
        q.delete();
        z = '{default: 0};
        z.hpk = 1;
        q.push_back(z);
        model_step(1'b1, 1'b1, 1'b0, 0, 0, 0, r);
        q.push_back(r);
        pv_cnt = 0;
    endtask

    // drives one frame; a line may be lengthened/shortened and reset may be applied at a line start
    task automatic run_frame(input int short_line, input int delta, input bit rand_col, input int rst_line);
        int len;
        bit bl, hs, vs;
        logic [8:0] col;
        for (int line = 0; line < V_TOT; line++) begin
            if (line == rst_line) do_reset(3);
            len = H_TOT + ((line == short_line) ? delta : 0);
            for (int c = 0; c < len; c++) begin
                bl = (line < V_ACT) && (c < H_ACT);
                hs = !((c >= HS_START) && (c < HS_START + HS_W));
                vs = !(((line == VS_LINE) && (c >= HS_START)) || (line == VS_LINE + 1) ||
                       ((line == VS_LINE + 2) && (c < HS_START)));
                if (bl && !rand_col) col = 9'(c);
                else col = 9'($urandom);
                tick(hs, vs, bl, col, c, line);
            end
        end
    endtask

    initial begin
        int sl, dl;
        resetn = 1'b0;
        hs_n = 1'b1; vs_n = 1'b1; blank_n = 1'b0; color_in = '0;
        model_reset();
        clr_mon();
        do_reset(4);

        // acquisition: search vs fall + two clean frames
        clr_mon();
        repeat (3) run_frame(-1, 0, 1'b1, -1);
        check_eq("lock_after_3", 32'(locked), 1);
        check_eq("lock_h_period", 32'(h_period), H_TOT);
        check_eq("lock_v_lines", 32'(v_lines), V_TOT);
        check_eq("lock_no_err", 32'(err_cnt), 0);

        // full locked frame with colour = x
        clr_mon();
        run_frame(-1, 0, 1'b0, -1);
        check_eq("pv_per_frame", 32'(pv_cnt), H_ACT * V_ACT);
        check_eq("fs_per_frame", 32'(fs_cnt), 1);
        check_eq("first_x", 32'(first_x), 0);
        check_eq("first_y", 32'(first_y), 0);
        check_eq("last_x", 32'(last_x), H_ACT - 1);
        check_eq("last_y", 32'(last_y), V_ACT - 1);

        // one short line while locked
        clr_mon();
        run_frame(5, -1, 1'b1, -1);
        check_eq("short_err_cnt", 32'(err_cnt), 1);
        check_eq("short_h_period", 32'(last_err_hp), H_TOT - 1);
        check_eq("short_unlock", 32'(last_err_lk), 0);
        repeat (2) run_frame(-1, 0, 1'b1, -1);
        check_eq("short_relock", 32'(locked), 1);
        check_eq("short_err_total", 32'(err_cnt), 1);

        // hs stuck high, hcnt saturates
        clr_mon();
        for (int i = 0; i < 3000; i++) tick(1'b1, 1'b1, 1'b0, 9'($urandom), 0, 0);
        run_frame(-1, 0, 1'b1, -1);
        check_eq("stall_err_cnt", 32'(err_cnt), 1);
        check_eq("stall_h_period", 32'(last_err_hp), 2047);
        check_eq("stall_unlock", 32'(locked), 0);
        repeat (2) run_frame(-1, 0, 1'b1, -1);
        check_eq("stall_relock", 32'(locked), 1);

        // reset mid-frame while locked
        clr_mon();
        run_frame(-1, 0, 1'b1, 6);
        run_frame(-1, 0, 1'b1, -1);
        check_eq("rst_no_pv", 32'(pv_cnt), 0);
        check_eq("rst_not_locked", 32'(locked), 0);
        run_frame(-1, 0, 1'b1, -1);
        check_eq("rst_relock", 32'(locked), 1);

        // random line-length disturbances and colours
        for (int f = 0; f < 6; f++) begin
            sl = -1;
            dl = 0;
            if ($urandom_range(0, 1) == 1) begin
                sl = int'($urandom_range(0, V_TOT - 1));
                case ($urandom_range(0, 3))
                    0: dl = -2;
                    1: dl = -1;
                    2: dl = 1;
                    default: dl = 2;
                endcase
            end
            run_frame(sl, dl, 1'b1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_sync_receiver.md
Name: vga_sync_receiver

Overview:
- Receive end of the VGA link the display controller drives; clocked on the same vga_clock.
- Consumes HS/VS/BLANK_N plus packed pixel colour and recovers per-pixel x/y coordinates.
- Measures line and frame timing against the 640x480 timing and reports lock and timing errors.
- Used as an in-system monitor and as the bench-side checker for the display path.

Parameters:
- H_TOTAL, 800, clocks per line (hs falling edge to hs falling edge)
- V_TOTAL, 525, lines per frame (vs falling edge to vs falling edge)
- H_ACTIVE, 640, active pixels per line (blank_n high run length)
- V_ACTIVE, 480, active lines per frame
- COLOR_DEPTH, 9, packed RGB width
- LOCK_FRAMES, 2, consecutive clean frames required to lock (1..7)

Ports:
- vga_clock  in  1  pixel clock
- resetn  in  1  asynchronous active-low reset
- hs_n  in  1  horizontal sync, active low
- vs_n  in  1  vertical sync, active low
- blank_n  in  1  high during active video
- color_in  in  COLOR_DEPTH  packed pixel colour
- rx_x  out  10  active-pixel column 0..H_ACTIVE-1
- rx_y  out  10  active-line row 0..V_ACTIVE-1
- rx_color  out  COLOR_DEPTH  colour aligned with rx_x/rx_y
- pixel_valid  out  1  rx_* hold a real pixel of a locked frame
- frame_start  out  1  one-cycle pulse at each vs falling edge while locked
- locked  out  1  timing lock achieved
- timing_err  out  1  one-cycle pulse on any timing mismatch
- h_period  out  11  last measured clocks per line, saturating at 2047
- v_lines  out  10  last measured lines per frame, saturating at 1023

Behaviour:
- Reset (asynchronous, resetn low): all outputs 0; all counters 0; FSM in SEARCH; input registers load hs_n=1, vs_n=1, blank_n=0.
- Stage 1 registers hs_n, vs_n, blank_n and color_in. Edges are detected by comparing stage 1 with the previous stage-1 value.
- Stage 2 registers the outputs. An input sampled at edge N appears on the outputs after edge N+1 (2-cycle latency).
- hcnt (11 b, saturating) counts clocks and clears on hs fall. At each hs fall, h_period <= hcnt+1 (saturating).
- line counter (10 b, saturating) increments on each hs fall and clears on vs fall. At each vs fall, v_lines <= line count.
- Active-pixel counter: clears on blank_n rise and increments while blank_n=1; it drives rx_x.
- Active-line counter: increments on each blank_n fall and clears on vs fall; it drives rx_y.
- pixel_valid = locked AND stage-1 blank_n. rx_color is passed through unconditionally.
- FSM states: SEARCH, MEASURE, LOCKED.
  - SEARCH: no checks performed. On the first vs fall -> MEASURE, good_cnt=0.
  - MEASURE and LOCKED check the following; any failure pulses timing_err for 1 cycle:
    - each hs fall: hcnt+1 == H_TOTAL
    - each blank_n fall: active-pixel count == H_ACTIVE
    - each vs fall: line count == V_TOTAL and active-line count == V_ACTIVE
  - MEASURE: on an error -> SEARCH. On a clean vs fall, good_cnt++; when good_cnt reaches LOCK_FRAMES -> LOCKED, locked=1.
  - LOCKED: on an error -> SEARCH, locked=0 on the same edge that timing_err pulses. frame_start pulses on every vs fall.
- Simultaneous hs fall and vs fall: the line check is evaluated first, then the frame check. Both use pre-clear counter values. A single timing_err pulse covers both.
- Saturation: hs stuck high -> hcnt stops at 2047. The next hs fall then fails the check. No wrap-around.
- Reset asserted mid-frame: immediate return to SEARCH with outputs 0. Re-lock requires a fresh vs fall plus LOCK_FRAMES clean frames.

Test Plan:
- Drive from vga_display_controller after reset -> locked rises at the end of frame 3 (one search vs fall + 2 clean frames); h_period=800; v_lines=525; timing_err never pulses.
- Locked, full frame -> first pixel_valid has rx_x=0, rx_y=0; last has rx_x=639, rx_y=479; exactly 307200 pixel_valid cycles per frame; one frame_start per frame.
- Colour alignment: drive colour = x[8:0] -> rx_color[8:0] == rx_x[8:0] on every valid cycle.
- Shorten one line to 799 clocks -> timing_err pulse at that hs fall; locked drops; h_period=799; relock after 2 further clean frames.
- Hold hs_n high for 3000 clocks -> h_period reads 2047 after the next hs fall; timing_err pulses; state returns to SEARCH.
- Assert resetn low at line 200 of a locked frame -> all outputs 0 asynchronously; after release, no pixel_valid until relock.
